// File: rtl/ocr_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and its surroundings: byte receiver,
// image buffer, inference core and result consumer.
interface ocr_frame_sequencer_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       buffer_full;
  logic       buffer_empty;
  logic       buffer_clear;
  logic       buffer_wr_en;
  logic [7:0] buffer_wr_data;
  logic       infer_start;
  logic       infer_done;
  logic [3:0] infer_digit;
  logic       result_valid;
  logic [3:0] result_digit;
  logic       result_ack;
  logic       error;
  logic       busy;
  logic [9:0] pixel_count;
  logic [2:0] state_dbg;

  modport slave (
    input  rx_valid, rx_data, buffer_full, buffer_empty,
           infer_done, infer_digit, result_ack,
    output buffer_clear, buffer_wr_en, buffer_wr_data, infer_start,
           result_valid, result_digit, error, busy, pixel_count, state_dbg
  );

  modport master (
    output rx_valid, rx_data, buffer_full, buffer_empty,
           infer_done, infer_digit, result_ack,
    input  buffer_clear, buffer_wr_en, buffer_wr_data, infer_start,
           result_valid, result_digit, error, busy, pixel_count, state_dbg
  );
endinterface

// File: rtl/ocr_frame_sequencer.sv
// Frame sequencer: start byte -> buffer clear -> pixel load -> inference start
// -> bounded wait for the digit -> hold result until acknowledged.
module ocr_frame_sequencer #(
  parameter int unsigned NUM_PIXELS    = 784,
  parameter logic [7:0]  START_BYTE    = 8'hA5,
  parameter int unsigned INFER_TIMEOUT = 100000,
  parameter int unsigned FULL_TIMEOUT  = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  ocr_frame_sequencer_if.slave  bus
);

  localparam int unsigned       TMO_W      = $clog2(INFER_TIMEOUT + 1);
  localparam logic [9:0]        PIX_MAX    = 10'(NUM_PIXELS);
  localparam logic [9:0]        PIX_LAST   = 10'(NUM_PIXELS - 1);
  localparam logic [TMO_W-1:0]  FULL_LAST  = TMO_W'(FULL_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  INFER_LAST = TMO_W'(INFER_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_ARM    = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_RESULT = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_frame_go;
  logic              w_pix_acc;
  logic              w_arm_tmo;
  logic              w_wait_tmo;

  logic [TMO_W-1:0]  r_tmo;
  logic [9:0]        r_pix_cnt;
  logic              r_clear;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;
  logic              r_infer_start;
  logic              r_res_valid;
  logic [3:0]        r_res_digit;
  logic              r_error;
  logic              r_busy;

  // Buffer occupancy is tracked by the buffer itself; only buffer_full gates sequencing.
  logic              w_unused_status;
  assign w_unused_status = bus.buffer_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_frame_go = 1'b0;
    w_pix_acc  = 1'b0;
    w_arm_tmo  = 1'b0;
    w_wait_tmo = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == START_BYTE)) begin
          w_frame_go = 1'b1;
          w_next     = S_CLEAR;
        end
      end
      S_CLEAR: w_next = S_LOAD;
      S_LOAD: begin
        // Inside a frame every byte is pixel data, including the start-byte value.
        if (bus.rx_valid && (r_pix_cnt < PIX_MAX)) begin
          w_pix_acc = 1'b1;
          if (r_pix_cnt == PIX_LAST) begin
            w_next = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (bus.buffer_full) begin
          w_next = S_START;
        end else if (r_tmo == FULL_LAST) begin
          w_arm_tmo = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.infer_done) begin
          w_next = S_RESULT;
        end else if (r_tmo == INFER_LAST) begin
          w_wait_tmo = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_RESULT: begin
        if (bus.result_ack) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo         <= '0;
      r_pix_cnt     <= '0;
      r_clear       <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_data     <= '0;
      r_infer_start <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_digit   <= '0;
      r_error       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_busy        <= (w_next != S_IDLE);
      r_clear       <= w_frame_go;
      r_infer_start <= (w_next == S_START) && (r_state != S_START);
      r_wr_en       <= w_pix_acc;

      if (w_pix_acc) begin
        r_wr_data <= bus.rx_data;
        r_pix_cnt <= r_pix_cnt + 10'd1;
      end else if (r_state == S_CLEAR) begin
        r_pix_cnt <= '0;
      end

      // One counter serves both ARM and WAIT; it restarts on every state change.
      if (w_next != r_state) begin
        r_tmo <= '0;
      end else if (r_tmo != TMO_MAX) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_frame_go) begin
        r_error <= 1'b0;
      end else if (w_arm_tmo || w_wait_tmo) begin
        r_error <= 1'b1;
      end

      if ((r_state == S_WAIT) && bus.infer_done) begin
        r_res_valid <= 1'b1;
        r_res_digit <= bus.infer_digit;
      end else if ((r_state == S_RESULT) && bus.result_ack) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.buffer_clear   = r_clear;
  assign bus.buffer_wr_en   = r_wr_en;
  assign bus.buffer_wr_data = r_wr_data;
  assign bus.infer_start    = r_infer_start;
  assign bus.result_valid   = r_res_valid;
  assign bus.result_digit   = r_res_digit;
  assign bus.error          = r_error;
  assign bus.busy           = r_busy;
  assign bus.pixel_count    = r_pix_cnt;
  assign bus.state_dbg      = r_state;

endmodule

// File: tb/tb_ocr_frame_sequencer.sv
// Randomized bench for ocr_frame_sequencer with behavioural buffer/core models
// and a write scoreboard built from the bytes the driver sends.
module tb_ocr_frame_sequencer;
  localparam int NPIX = 784;
  localparam int ITMO = 200;
  localparam int FTMO = 16;
  localparam int LIM  = ITMO + 600;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ocr_frame_sequencer_if bus();

  ocr_frame_sequencer #(
    .NUM_PIXELS(NPIX), .START_BYTE(8'hA5),
    .INFER_TIMEOUT(ITMO), .FULL_TIMEOUT(FTMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } wr_t;
  wr_t exp_wr[$];

  int n_clear = 0;
  int n_start = 0;
  int buf_cnt = 0;
  bit withhold = 1'b0;
  bit core_resp = 1'b1;
  logic [3:0] core_digit = 4'd0;
  int core_cd = 0;

  // Monitor, image-buffer model and inference-core model, all on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    if (bus.buffer_clear) n_clear++;
    if (bus.infer_start) n_start++;
    if (bus.buffer_wr_en) begin
      check_eq("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        check_eq("wr_data", 32'(bus.buffer_wr_data), 32'(e.d));
        check_eq("wr_latency", cyc, e.c);
      end
    end
    bus.buffer_full = !withhold && (buf_cnt >= NPIX);
    if (bus.buffer_clear) buf_cnt = 0;
    else if (bus.buffer_wr_en) buf_cnt++;
    bus.buffer_empty = (buf_cnt == 0);
    bus.infer_done = 1'b0;
    if (bus.infer_start) core_cd = 50;
    else if (core_cd > 0) begin
      core_cd--;
      if (core_cd == 0 && core_resp) begin
        bus.infer_done  = 1'b1;
        bus.infer_digit = core_digit;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit expect_wr);
    wr_t e;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (expect_wr) begin
      e.d = b;
      e.c = cyc + 1;
      exp_wr.push_back(e);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic open_frame();
    send_byte(8'hA5, 1'b0);
    check_eq("clear_state", 32'(bus.state_dbg), 32'd1);
    check_eq("clear_pulse", 32'(bus.buffer_clear), 32'd1);
    check_eq("err_cleared", 32'(bus.error), 32'd0);
    check_eq("busy_frame", 32'(bus.busy), 32'd1);
  endtask

  // pat 0: pixel = index mod 256; pat 1: random pixels with the start value at index 10.
  task automatic run_frame(input int pat, input bit full_ok, input bit done_ok,
                           input logic [3:0] dg, input bit noise);
    int c0, s0, arm_cyc, wait_cyc, k;
    bit nd;
    logic [7:0] b;
    c0 = n_clear; s0 = n_start; arm_cyc = 0; wait_cyc = 0; k = 0; nd = 1'b0;
    withhold = !full_ok;
    core_resp = done_ok;
    core_digit = dg;
    open_frame();
    for (int i = 0; i < NPIX; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      if (pat == 0) b = 8'(i);
      else if (i == 10) b = 8'hA5;
      else b = 8'($urandom);
      send_byte(b, 1'b1);
    end
    check_eq("pix_count_full", 32'(bus.pixel_count), 32'(NPIX));
    while (k < LIM && bus.state_dbg != 3'd6 && bus.state_dbg != 3'd0) begin
      if (bus.state_dbg == 3'd3) arm_cyc++;
      if (bus.state_dbg == 3'd5) wait_cyc++;
      if (noise && !nd && bus.state_dbg == 3'd5) begin
        nd = 1'b1;
        send_byte(8'hA5, 1'b0);
        repeat (3) send_byte(8'($urandom), 1'b0);
      end
      @(negedge clk);
      k++;
    end
    check_eq("frame_bound", 32'(k < LIM), 32'd1);
    if (full_ok && done_ok) begin
      check_eq("res_state", 32'(bus.state_dbg), 32'd6);
      check_eq("res_valid", 32'(bus.result_valid), 32'd1);
      check_eq("res_digit", 32'(bus.result_digit), 32'(dg));
      repeat ($urandom_range(1, 8)) @(negedge clk);
      if (noise) repeat (2) send_byte(8'($urandom), 1'b0);
      check_eq("res_hold_valid", 32'(bus.result_valid), 32'd1);
      check_eq("res_hold_digit", 32'(bus.result_digit), 32'(dg));
      check_eq("res_hold_state", 32'(bus.state_dbg), 32'd6);
      bus.result_ack = 1'b1;
      @(negedge clk);
      bus.result_ack = 1'b0;
      check_eq("ack_idle", 32'(bus.state_dbg), 32'd0);
      check_eq("ack_valid", 32'(bus.result_valid), 32'd0);
      check_eq("ack_busy", 32'(bus.busy), 32'd0);
      check_eq("ack_err", 32'(bus.error), 32'd0);
    end else if (full_ok) begin
      check_eq("itmo_idle", 32'(bus.state_dbg), 32'd0);
      check_eq("itmo_err", 32'(bus.error), 32'd1);
      check_eq("itmo_valid", 32'(bus.result_valid), 32'd0);
      check_eq("itmo_cycles", wait_cyc, ITMO);
    end else begin
      check_eq("ftmo_idle", 32'(bus.state_dbg), 32'd0);
      check_eq("ftmo_err", 32'(bus.error), 32'd1);
      check_eq("ftmo_cycles", arm_cyc, FTMO);
    end
    repeat (2) @(negedge clk);
    check_eq("n_clear", n_clear - c0, 1);
    check_eq("n_start", n_start - s0, full_ok ? 1 : 0);
    check_eq("pix_count_sat", 32'(bus.pixel_count), 32'(NPIX));
    check_eq("wr_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.result_ack = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_state", 32'(bus.state_dbg), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_err", 32'(bus.error), 32'd0);
    check_eq("rst_pix", 32'(bus.pixel_count), 32'd0);
    check_eq("rst_strobes", 32'({bus.buffer_clear, bus.buffer_wr_en, bus.infer_start}), 32'd0);
    check_eq("rst_result", 32'({bus.result_valid, bus.result_digit}), 32'd0);
    check_eq("rst_wr_data", 32'(bus.buffer_wr_data), 32'd0);

    send_byte(8'h12, 1'b0);
    @(negedge clk);
    check_eq("idle_ignore_state", 32'(bus.state_dbg), 32'd0);
    check_eq("idle_ignore_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_ignore_clear", n_clear, 0);

    run_frame(0, 1'b1, 1'b1, 4'd7, 1'b0);
    run_frame(1, 1'b1, 1'b1, 4'($urandom_range(0, 9)), 1'b0);
    run_frame(1, 1'b1, 1'b0, 4'd0, 1'b0);
    run_frame(1, 1'b0, 1'b1, 4'd0, 1'b0);

    withhold = 1'b0;
    core_resp = 1'b1;
    open_frame();
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      send_byte(8'($urandom), 1'b1);
    end
    @(negedge clk);
    check_eq("mid_pix", 32'(bus.pixel_count), 32'd300);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(bus.state_dbg), 32'd0);
    check_eq("mid_rst_pix", 32'(bus.pixel_count), 32'd0);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_clear", 32'(bus.buffer_clear), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_wr_drained", 32'(exp_wr.size()), 32'd0);

    run_frame(1, 1'b1, 1'b1, 4'($urandom_range(0, 9)), 1'b1);
    run_frame(0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
